// File: rtl/keypad_operand_loader.sv
// Keypad front end for the Booth multiplier: builds decimal operands A and B from
// key presses and hands the committed pair over a valid/ready handshake.
module keypad_operand_loader #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3,
    parameter int SIGNED     = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        key_value,
    input  logic                              key_pressed,
    input  logic                              op_ready,
    output logic                              op_valid,
    output logic [WIDTH-1:0]                  op_a,
    output logic [WIDTH-1:0]                  op_b,
    output logic [WIDTH-1:0]                  temp_value,
    output logic                              temp_neg,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic                              entering_b,
    output logic                              key_err
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int XW = WIDTH + 4;
    localparam logic [CW-1:0] MAXD = CW'(MAX_DIGITS);

    typedef enum logic [1:0] {ENTER_A, ENTER_B, WAIT_ACK} state_t;

    state_t            state_q, state_d;
    logic              key_prev_q, key_prev_d;
    logic              op_valid_q, op_valid_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [WIDTH-1:0]  temp_q, temp_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              press;
    logic [XW-1:0]     nxt;
    logic [WIDTH-1:0]  commit_val;

    // Largest magnitude an entry may hold for the given sign.
    function automatic logic [XW-1:0] max_mag(input logic neg);
        logic [XW-1:0] half;
        half = XW'(1) << (WIDTH - 1);
        if (SIGNED == 0)
            return (half << 1) - XW'(1);
        else if (neg)
            return half;
        else
            return half - XW'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        key_prev_d = key_pressed;
        op_valid_d = op_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        temp_d     = temp_q;
        neg_d      = neg_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;

        press      = key_pressed & ~key_prev_q;
        nxt        = ({4'b0000, temp_q} * XW'(10)) + {{WIDTH{1'b0}}, key_value};
        commit_val = neg_q ? (WIDTH'(0) - temp_q) : temp_q;

        case (state_q)
            ENTER_A, ENTER_B: begin
                if (press) begin
                    if (key_value <= 4'd9) begin
                        if ((cnt_q < MAXD) && (nxt <= max_mag(neg_q))) begin
                            temp_d = nxt[WIDTH-1:0];
                            cnt_d  = cnt_q + CW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (key_value)
                            4'hA: begin
                                if (cnt_q == '0) begin
                                    err_d = 1'b1;
                                end else begin
                                    if (state_q == ENTER_A) begin
                                        op_a_d  = commit_val;
                                        state_d = ENTER_B;
                                    end else begin
                                        op_b_d     = commit_val;
                                        op_valid_d = 1'b1;
                                        state_d    = WAIT_ACK;
                                    end
                                    temp_d = '0;
                                    neg_d  = 1'b0;
                                    cnt_d  = '0;
                                end
                            end
                            4'hB: begin
                                temp_d = '0;
                                neg_d  = 1'b0;
                                cnt_d  = '0;
                            end
                            4'hC: begin
                                temp_d  = '0;
                                neg_d   = 1'b0;
                                cnt_d   = '0;
                                op_a_d  = '0;
                                op_b_d  = '0;
                                state_d = ENTER_A;
                            end
                            4'hD: begin
                                // A negative entry at the most-negative value has no positive twin.
                                if (SIGNED == 0)
                                    err_d = 1'b1;
                                else if (neg_q && ({4'b0000, temp_q} > max_mag(1'b0)))
                                    err_d = 1'b1;
                                else
                                    neg_d = ~neg_q;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WAIT_ACK: begin
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = ENTER_A;
                end
            end
            default: state_d = ENTER_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ENTER_A;
            key_prev_q <= 1'b1;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            temp_q     <= '0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_prev_d;
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            temp_q     <= temp_d;
            neg_q      <= neg_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign op_valid    = op_valid_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign temp_value  = temp_q;
    assign temp_neg    = neg_q;
    assign digit_count = cnt_q;
    assign entering_b  = (state_q == ENTER_B);
    assign key_err     = err_q;

endmodule

// File: tb/tb_keypad_operand_loader.sv
// Bench for keypad_operand_loader: signed 8-bit instance plus an unsigned instance
// sharing the same keypad; committed pairs are checked through a scoreboard queue.
module tb_keypad_operand_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_value = 4'h0;
    logic       key_pressed = 1'b0;
    logic       op_ready = 1'b1;

    logic       op_valid, temp_neg, entering_b, key_err;
    logic [7:0] op_a, op_b, temp_value;
    logic [1:0] digit_count;

    logic       u_op_valid, u_temp_neg, u_entering_b, u_key_err;
    logic [7:0] u_op_a, u_op_b, u_temp_value;
    logic [1:0] u_digit_count;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    logic err1, err2, uerr1, v1, v2;

    always #5 clk = ~clk;

    keypad_operand_loader #(.WIDTH(8), .MAX_DIGITS(3), .SIGNED(1)) u_dut (
        .clk(clk), .rst(rst), .key_value(key_value), .key_pressed(key_pressed),
        .op_ready(op_ready), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
        .temp_value(temp_value), .temp_neg(temp_neg), .digit_count(digit_count),
        .entering_b(entering_b), .key_err(key_err)
    );

    keypad_operand_loader #(.WIDTH(8), .MAX_DIGITS(3), .SIGNED(0)) u_uns (
        .clk(clk), .rst(rst), .key_value(key_value), .key_pressed(key_pressed),
        .op_ready(op_ready), .op_valid(u_op_valid), .op_a(u_op_a), .op_b(u_op_b),
        .temp_value(u_temp_value), .temp_neg(u_temp_neg), .digit_count(u_digit_count),
        .entering_b(u_entering_b), .key_err(u_key_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic press(input logic [3:0] k);
        @(posedge clk); #1;
        key_value = k;
        key_pressed = 1'b1;
        @(posedge clk); #1;
        key_pressed = 1'b0;
        err1 = key_err; uerr1 = u_key_err; v1 = op_valid;
        @(posedge clk); #1;
        err2 = key_err; v2 = op_valid;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard: a pair leaves the DUT on an accepted handshake.
    always @(negedge clk) begin
        if (!rst && op_valid && op_ready) begin
            chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("sb_op_a", 32'(op_a), 32'(e[15:8]));
                chk("sb_op_b", 32'(op_b), 32'(e[7:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation bound %0d expected 0", 200000);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk("rst_op_valid", 32'(op_valid), 0);
        chk("rst_op_a", 32'(op_a), 0);
        chk("rst_op_b", 32'(op_b), 0);
        chk("rst_temp", 32'(temp_value), 0);
        chk("rst_neg", 32'(temp_neg), 0);
        chk("rst_count", 32'(digit_count), 0);
        chk("rst_entering_b", 32'(entering_b), 0);
        chk("rst_key_err", 32'(key_err), 0);

        // Basic A/B entry and handshake.
        op_ready = 1'b1;
        press(4'h1); press(4'h2); press(4'h3);
        chk("t1_temp", 32'(temp_value), 123);
        chk("t1_count", 32'(digit_count), 3);
        press(4'hA);
        chk("t1_op_a", 32'(op_a), 123);
        chk("t1_entering_b", 32'(entering_b), 1);
        chk("t1_temp_clr", 32'(temp_value), 0);
        press(4'h4); press(4'h5);
        exp_q.push_back({8'd123, 8'd45});
        press(4'hA);
        chk("t1_valid_pulse", 32'(v1), 1);
        chk("t1_valid_drop", 32'(v2), 0);
        chk("t1_entering_b_a", 32'(entering_b), 0);

        // Overflow rejection and most-negative value.
        press(4'h1); press(4'h2); press(4'h9);
        chk("t2_err", 32'(err1), 1);
        chk("t2_err_once", 32'(err2), 0);
        chk("t2_temp", 32'(temp_value), 12);
        chk("t2_count", 32'(digit_count), 2);
        press(4'hB);
        chk("t2_clr_temp", 32'(temp_value), 0);
        press(4'hD);
        chk("t2_neg", 32'(temp_neg), 1);
        press(4'h1); press(4'h2); press(4'h8);
        chk("t2_128_ok", 32'(err1), 0);
        chk("t2_temp128", 32'(temp_value), 128);
        press(4'hD);
        chk("t2_neg_blocked", 32'(err1), 1);
        chk("t2_neg_kept", 32'(temp_neg), 1);
        press(4'hA);
        chk("t2_op_a_min", 32'(op_a), 32'h80);
        chk("t2_entering_b", 32'(entering_b), 1);

        // Digit limit.
        press(4'h0); press(4'h0); press(4'h1); press(4'h5);
        chk("t3_err", 32'(err1), 1);
        chk("t3_temp", 32'(temp_value), 1);
        chk("t3_count", 32'(digit_count), 3);
        press(4'hC);
        chk("t3_clr_op_a", 32'(op_a), 0);
        chk("t3_clr_entering_b", 32'(entering_b), 0);
        chk("t3_clr_temp", 32'(temp_value), 0);

        // Empty commit, clear entry, clear all.
        press(4'hA);
        chk("t4_empty_err", 32'(err1), 1);
        chk("t4_state_a", 32'(entering_b), 0);
        press(4'h7); press(4'hB); press(4'h9); press(4'hA);
        chk("t4_op_a", 32'(op_a), 9);
        chk("t4_entering_b", 32'(entering_b), 1);
        press(4'hC);
        chk("t4_c_op_a", 32'(op_a), 0);
        chk("t4_c_entering_b", 32'(entering_b), 0);

        // Backpressure.
        op_ready = 1'b0;
        press(4'h3); press(4'hA); press(4'h6);
        exp_q.push_back({8'd3, 8'd6});
        press(4'hA);
        chk("t5_valid", 32'(v1), 1);
        for (int i = 0; i < 8; i++) begin
            press(4'h5);
            chk("t5_wait_err", 32'(err1), 0);
            chk("t5_wait_valid", 32'(op_valid), 1);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("t5_wait_temp", 32'(temp_value), 0);
        chk("t5_stable_a", 32'(op_a), 3);
        chk("t5_stable_b", 32'(op_b), 6);
        op_ready = 1'b1;
        key_value = 4'h7;
        key_pressed = 1'b1;
        @(posedge clk); #1;
        key_pressed = 1'b0;
        chk("t5_ack_valid", 32'(op_valid), 0);
        chk("t5_ack_state", 32'(entering_b), 0);
        chk("t5_ack_press_ignored", 32'(temp_value), 0);
        chk("t5_retain_a", 32'(op_a), 3);

        // Negative zero commits as zero.
        press(4'h0); press(4'hD); press(4'hA);
        chk("t5_neg_zero", 32'(op_a), 0);
        press(4'hC);

        // Key held across reset, long hold, reset mid-entry.
        @(posedge clk); #1;
        key_value = 4'h4;
        key_pressed = 1'b1;
        do_reset();
        repeat (3) @(posedge clk);
        #1 key_pressed = 1'b0;
        chk("t6_held_rst_temp", 32'(temp_value), 0);
        chk("t6_held_rst_count", 32'(digit_count), 0);
        @(posedge clk); #1;
        key_value = 4'h6;
        key_pressed = 1'b1;
        repeat (10) @(posedge clk);
        #1 key_pressed = 1'b0;
        chk("t6_hold_temp", 32'(temp_value), 6);
        chk("t6_hold_count", 32'(digit_count), 1);
        press(4'hA); press(4'hD); press(4'h2);
        chk("t6_pre_rst_b", 32'(entering_b), 1);
        do_reset();
        chk("t6_rst_op_a", 32'(op_a), 0);
        chk("t6_rst_temp", 32'(temp_value), 0);
        chk("t6_rst_neg", 32'(temp_neg), 0);
        chk("t6_rst_count", 32'(digit_count), 0);
        chk("t6_rst_b", 32'(entering_b), 0);
        chk("t6_rst_valid", 32'(op_valid), 0);

        // Unsigned instance: full 8-bit range, negate rejected.
        press(4'h2); press(4'h5); press(4'h5);
        chk("t6u_err", 32'(uerr1), 0);
        chk("t6u_temp", 32'(u_temp_value), 255);
        press(4'hD);
        chk("t6u_neg_err", 32'(uerr1), 1);
        chk("t6u_neg_flag", 32'(u_temp_neg), 0);
        press(4'hA);
        chk("t6u_op_a", 32'(u_op_a), 255);
        press(4'hC);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
